// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit between the memory stage and a single-word data memory port.
// Holds the pipeline while a legal access waits for DReady; flags illegal accesses with a one-cycle pulse.
module lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq_M,
  input  logic        MemWE_M,
  input  logic [2:0]  Funct3_M,
  input  logic [31:0] Addr_M,
  input  logic [31:0] WriteData_M,
  input  logic [4:0]  A4_M,
  input  logic        DReady,
  input  logic [31:0] DRData,
  output logic        Stall_LSU,
  output logic        DReq,
  output logic        DWE,
  output logic [31:0] DAddr,
  output logic [3:0]  DByteEn,
  output logic [31:0] DWData,
  output logic        RegWE_W,
  output logic [4:0]  A4_W,
  output logic [31:0] ReadData,
  output logic        MisalignExc
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_next;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  a4_q;
  logic        legal;
  logic        accept;
  logic        complete;
  logic [31:0] lane_data;
  logic [31:0] load_data;

  // Stores never use the unsigned encodings; anything else outside B/H/W/BU/HU is illegal.
  always_comb begin
    legal = 1'b0;
    case (Funct3_M)
      3'b000, 3'b100: legal = 1'b1;
      3'b001, 3'b101: legal = ~Addr_M[0];
      3'b010:         legal = (Addr_M[1:0] == 2'b00);
      default:        legal = 1'b0;
    endcase
    if (MemWE_M && Funct3_M[2])
      legal = 1'b0;
  end

  assign accept   = (state == IDLE) && MemReq_M && legal;
  assign complete = (state == ACCESS) && DReady;

  always_comb begin
    state_next = state;
    Stall_LSU  = 1'b0;
    DReq       = 1'b0;
    case (state)
      IDLE: begin
        Stall_LSU = MemReq_M & legal;
        if (accept)
          state_next = ACCESS;
      end
      ACCESS: begin
        Stall_LSU = 1'b1;
        DReq      = 1'b1;
        if (DReady)
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus fields are zero outside ACCESS so reset and idle look identical on the port.
  always_comb begin
    DWE     = 1'b0;
    DAddr   = 32'h0;
    DByteEn = 4'b0000;
    DWData  = 32'h0;
    if (state == ACCESS) begin
      DAddr   = {addr_q[31:2], 2'b00};
      DByteEn = 4'b1111;
      if (we_q) begin
        DWE = 1'b1;
        case (f3_q[1:0])
          2'b00: begin
            DByteEn = 4'b0001 << addr_q[1:0];
            DWData  = {4{wdata_q[7:0]}};
          end
          2'b01: begin
            DByteEn = 4'b0011 << addr_q[1:0];
            DWData  = {2{wdata_q[15:0]}};
          end
          default: DWData = wdata_q;
        endcase
      end
    end
  end

  assign lane_data = DRData >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_data = DRData;
    case (f3_q)
      3'b000:  load_data = {{24{lane_data[7]}}, lane_data[7:0]};
      3'b100:  load_data = {24'h0, lane_data[7:0]};
      3'b001:  load_data = {{16{lane_data[15]}}, lane_data[15:0]};
      3'b101:  load_data = {16'h0, lane_data[15:0]};
      default: load_data = DRData;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      a4_q        <= 5'd0;
      RegWE_W     <= 1'b0;
      A4_W        <= 5'd0;
      ReadData    <= 32'h0;
      MisalignExc <= 1'b0;
    end else begin
      state       <= state_next;
      MisalignExc <= (state == IDLE) && MemReq_M && !legal;
      RegWE_W     <= complete && !we_q && (a4_q != 5'd0);
      if (accept) begin
        we_q    <= MemWE_M;
        f3_q    <= Funct3_M;
        addr_q  <= Addr_M;
        wdata_q <= WriteData_M;
        a4_q    <= A4_M;
      end
      if (complete && !we_q) begin
        ReadData <= load_data;
        A4_W     <= a4_q;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReq_M;
  logic        MemWE_M;
  logic [2:0]  Funct3_M;
  logic [31:0] Addr_M;
  logic [31:0] WriteData_M;
  logic [4:0]  A4_M;
  logic        DReady;
  logic [31:0] DRData;
  logic        Stall_LSU;
  logic        DReq;
  logic        DWE;
  logic [31:0] DAddr;
  logic [3:0]  DByteEn;
  logic [31:0] DWData;
  logic        RegWE_W;
  logic [4:0]  A4_W;
  logic [31:0] ReadData;
  logic        MisalignExc;

  int checks = 0;
  int failures = 0;
  int stall_cycles;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .reset(reset), .MemReq_M(MemReq_M), .MemWE_M(MemWE_M),
    .Funct3_M(Funct3_M), .Addr_M(Addr_M), .WriteData_M(WriteData_M), .A4_M(A4_M),
    .DReady(DReady), .DRData(DRData), .Stall_LSU(Stall_LSU), .DReq(DReq), .DWE(DWE),
    .DAddr(DAddr), .DByteEn(DByteEn), .DWData(DWData), .RegWE_W(RegWE_W),
    .A4_W(A4_W), .ReadData(ReadData), .MisalignExc(MisalignExc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then wait so new inputs and samples sit well away from it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic request(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] a4);
    MemReq_M = 1'b1; MemWE_M = we; Funct3_M = f3; Addr_M = addr; WriteData_M = wd; A4_M = a4;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_dreq"}, {31'h0, DReq}, 32'h0);
    chk({tag, "_dwe"}, {31'h0, DWE}, 32'h0);
    chk({tag, "_daddr"}, DAddr, 32'h0);
    chk({tag, "_dbyteen"}, {28'h0, DByteEn}, 32'h0);
    chk({tag, "_dwdata"}, DWData, 32'h0);
    chk({tag, "_regwe"}, {31'h0, RegWE_W}, 32'h0);
    chk({tag, "_a4w"}, {27'h0, A4_W}, 32'h0);
    chk({tag, "_rdata"}, ReadData, 32'h0);
    chk({tag, "_exc"}, {31'h0, MisalignExc}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; MemReq_M = 1'b0; MemWE_M = 1'b0; Funct3_M = 3'b000; Addr_M = 32'h0;
    WriteData_M = 32'h0; A4_M = 5'd0; DReady = 1'b0; DRData = 32'h0;
    #2;
    tick();
    tick();
    #1;
    check_idle_outputs("reset");
    chk("reset_stall", {31'h0, Stall_LSU}, 32'h0);
    reset = 1'b0;

    // LB 0x103: byte 0x80 sign-extends; stall for the request cycle and the ACCESS cycle
    stall_cycles = 0;
    request(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd5);
    #1;
    chk("lb_idle_stall", {31'h0, Stall_LSU}, 32'h1);
    chk("lb_idle_dreq", {31'h0, DReq}, 32'h0);
    stall_cycles += int'(Stall_LSU);
    tick();
    MemReq_M = 1'b0; DReady = 1'b1; DRData = 32'h80AA_BBCC;
    #1;
    stall_cycles += int'(Stall_LSU);
    chk("lb_acc_dreq", {31'h0, DReq}, 32'h1);
    chk("lb_acc_daddr", DAddr, 32'h0000_0100);
    chk("lb_acc_be", {28'h0, DByteEn}, 32'hF);
    chk("lb_acc_dwe", {31'h0, DWE}, 32'h0);
    chk("lb_acc_regwe", {31'h0, RegWE_W}, 32'h0);
    tick();
    DReady = 1'b0;
    request(1'b0, 3'b010, 32'h0000_0000, 32'h0, 5'd1);
    #1;
    stall_cycles += int'(Stall_LSU);
    chk("lb_done_regwe", {31'h0, RegWE_W}, 32'h1);
    chk("lb_done_rdata", ReadData, 32'hFFFF_FF80);
    chk("lb_done_a4w", {27'h0, A4_W}, 32'd5);
    chk("lb_done_dreq", {31'h0, DReq}, 32'h0);
    tick();
    MemReq_M = 1'b0;
    #1;
    stall_cycles += int'(Stall_LSU);
    chk("lb_stall_total", stall_cycles, 32'd2);
    chk("lb_after_regwe", {31'h0, RegWE_W}, 32'h0);
    chk("lb_done_ignored_dreq", {31'h0, DReq}, 32'h0);
    tick();
    chk("lb_still_idle_dreq", {31'h0, DReq}, 32'h0);

    // LHU 0x202 with DReady three cycles late; address must not move while waiting
    request(1'b0, 3'b101, 32'h0000_0202, 32'h0, 5'd7);
    tick();
    MemReq_M = 1'b0; DReady = 1'b0; DRData = 32'h8001_1234;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lhu_wait_dreq", {31'h0, DReq}, 32'h1);
      chk("lhu_wait_daddr", DAddr, 32'h0000_0200);
      chk("lhu_wait_regwe", {31'h0, RegWE_W}, 32'h0);
      tick();
    end
    DReady = 1'b1;
    #1;
    chk("lhu_last_dreq", {31'h0, DReq}, 32'h1);
    chk("lhu_last_daddr", DAddr, 32'h0000_0200);
    tick();
    DReady = 1'b0;
    #1;
    chk("lhu_dreq_drop", {31'h0, DReq}, 32'h0);
    chk("lhu_rdata", ReadData, 32'h0000_8001);
    chk("lhu_a4w", {27'h0, A4_W}, 32'd7);
    chk("lhu_regwe", {31'h0, RegWE_W}, 32'h1);
    tick();

    // SB 0x11: lane 1, byte replicated, no writeback, ReadData/A4_W keep prior load
    request(1'b1, 3'b000, 32'h0000_0011, 32'h0000_00A5, 5'd3);
    tick();
    MemReq_M = 1'b0; DReady = 1'b1;
    #1;
    chk("sb_be", {28'h0, DByteEn}, 32'b0010);
    chk("sb_wdata", DWData, 32'hA5A5_A5A5);
    chk("sb_dwe", {31'h0, DWE}, 32'h1);
    chk("sb_daddr", DAddr, 32'h0000_0010);
    tick();
    DReady = 1'b0;
    #1;
    chk("sb_regwe", {31'h0, RegWE_W}, 32'h0);
    chk("sb_rdata_hold", ReadData, 32'h0000_8001);
    chk("sb_a4w_hold", {27'h0, A4_W}, 32'd7);
    chk("sb_done_dwe", {31'h0, DWE}, 32'h0);
    tick();

    // SH 0x22: upper halfword lanes
    request(1'b1, 3'b001, 32'h0000_0022, 32'h1234_BEEF, 5'd0);
    tick();
    MemReq_M = 1'b0; DReady = 1'b1;
    #1;
    chk("sh_be", {28'h0, DByteEn}, 32'b1100);
    chk("sh_wdata", DWData, 32'hBEEF_BEEF);
    tick();
    DReady = 1'b0;
    tick();

    // LW 0x6: misaligned, single exception pulse and no bus activity
    request(1'b0, 3'b010, 32'h0000_0006, 32'h0, 5'd4);
    #1;
    chk("lwmis_stall", {31'h0, Stall_LSU}, 32'h0);
    tick();
    MemReq_M = 1'b0;
    #1;
    chk("lwmis_exc", {31'h0, MisalignExc}, 32'h1);
    chk("lwmis_dreq", {31'h0, DReq}, 32'h0);
    chk("lwmis_regwe", {31'h0, RegWE_W}, 32'h0);
    tick();
    chk("lwmis_exc_clear", {31'h0, MisalignExc}, 32'h0);
    chk("lwmis_dreq2", {31'h0, DReq}, 32'h0);

    // Store with an unsigned encoding is illegal even when aligned
    request(1'b1, 3'b100, 32'h0000_0000, 32'h0, 5'd0);
    #1;
    chk("sbu_stall", {31'h0, Stall_LSU}, 32'h0);
    tick();
    MemReq_M = 1'b0;
    #1;
    chk("sbu_exc", {31'h0, MisalignExc}, 32'h1);
    chk("sbu_dreq", {31'h0, DReq}, 32'h0);
    tick();

    // DReady in IDLE does nothing
    DReady = 1'b1;
    tick();
    DReady = 1'b0;
    #1;
    chk("idle_dready_dreq", {31'h0, DReq}, 32'h0);
    chk("idle_dready_regwe", {31'h0, RegWE_W}, 32'h0);

    // Reset during ACCESS wins over a simultaneous DReady
    request(1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd9);
    tick();
    MemReq_M = 1'b0;
    #1;
    chk("rst_acc_dreq", {31'h0, DReq}, 32'h1);
    reset = 1'b1; DReady = 1'b1; DRData = 32'h1111_2222;
    tick();
    reset = 1'b0; DReady = 1'b0;
    #1;
    check_idle_outputs("rst_acc");
    chk("rst_acc_stall", {31'h0, Stall_LSU}, 32'h0);
    tick();
    chk("rst_acc_regwe2", {31'h0, RegWE_W}, 32'h0);
    chk("rst_acc_dreq2", {31'h0, DReq}, 32'h0);

    // LW 0x40 to x0: data captured but no writeback
    request(1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd0);
    tick();
    MemReq_M = 1'b0; DReady = 1'b1; DRData = 32'hDEAD_BEEF;
    #1;
    chk("lwx0_dreq", {31'h0, DReq}, 32'h1);
    tick();
    DReady = 1'b0;
    #1;
    chk("lwx0_regwe", {31'h0, RegWE_W}, 32'h0);
    chk("lwx0_rdata", ReadData, 32'hDEAD_BEEF);
    chk("lwx0_a4w", {27'h0, A4_W}, 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
